// File: rtl/rx_wb_pack_pkg.sv
// rtl/rx_wb_pack_pkg.sv - shared encodings and helpers for the wideband RX packer
package rx_wb_pack_pkg;

    typedef enum logic [1:0] {
        MODE_MSB16 = 2'd0,
        MODE_FULL  = 2'd1,
        MODE_PACK8 = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

    // Words each enabled channel contributes; the reserved encoding 3 behaves as MSB16.
    function automatic logic [1:0] wpc_of(input logic [1:0] mode);
        case (mode)
            MODE_FULL:  return 2'd3;
            MODE_PACK8: return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/rx_wb_fifo.sv
// rtl/rx_wb_fifo.sv - single-clock circular word buffer with occupancy and registered read
module rx_wb_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [15:0]              wr_data,
    input  logic                     rd_en,
    output logic [15:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // A pop on an empty buffer is ignored; a push into a full one cannot happen upstream
    assign do_rd = rd_en && (count != '0);
    assign do_wr = wr_en && (count != (AW+1)'(DEPTH));

    // Storage array; contents are only observable through count, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; read port is registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            count    <= '0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_wb_pack.sv
// rtl/rx_wb_pack.sv - multi-channel I/Q word packer feeding a readout FIFO; optional header via RX_WB_PACK_HDR_EN
import rx_wb_pack_pkg::*;

module rx_wb_pack #(
    parameter int NCH      = 4,
    parameter int IN_WIDTH = 18,
    parameter int DEPTH    = 64
) (
    input  logic                     adc_clk,
    input  logic                     reset,
    input  logic                     in_avail,
    input  logic [NCH*IN_WIDTH-1:0]  in_i,
    input  logic [NCH*IN_WIDTH-1:0]  in_q,
    input  logic [NCH-1:0]           ch_en,
    input  logic [1:0]               mode,
    input  logic                     rd_en,
    output logic [15:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = IN_WIDTH;

    state_t              state;
    state_t              next_state;
    logic [NCH*W-1:0]    hold_i;
    logic [NCH*W-1:0]    hold_q;
    logic [1:0]          mode_h;
    logic [NCH-1:0]      remain;
    logic [1:0]          word_idx;
    logic [CW-1:0]       set_len;
    logic [CW-1:0]       free_words;
    logic                accept;
    logic                drop;
    logic [W-1:0]        cur_i;
    logic [W-1:0]        cur_q;
    logic [NCH-1:0]      cur_bit;
    logic                last_word;
    logic                last_chan;
    logic                wr_en;
    logic [15:0]         wr_data;
`ifdef RX_WB_PACK_HDR_EN
    logic [11:0]         seq;
`endif

    // Builds one output word for the current channel from its held I/Q pair
    function automatic logic [15:0] fmt_word(input logic [1:0] md, input logic [1:0] idx,
                                             input logic [W-1:0] iv, input logic [W-1:0] qv);
        logic [7:0] i_hi;
        logic [7:0] q_hi;
        i_hi = 8'($signed(iv) >>> 16);
        q_hi = 8'($signed(qv) >>> 16);
        if (md == MODE_FULL) begin
            if (idx == 2'd0) return iv[15:0];
            if (idx == 2'd1) return qv[15:0];
            return {i_hi, q_hi};
        end
        if (md == MODE_PACK8) begin
            return {iv[W-1 -: 8], qv[W-1 -: 8]};
        end
        return (idx == 2'd0) ? iv[W-1 -: 16] : qv[W-1 -: 16];
    endfunction

    // Length of the set currently offered on the inputs, used for atomic admission
    always_comb begin
        set_len = '0;
        for (int k = 0; k < NCH; k++) begin
            set_len = set_len + CW'(ch_en[k]);
        end
        set_len = set_len * CW'(wpc_of(mode));
`ifdef RX_WB_PACK_HDR_EN
        set_len = set_len + CW'(1);
`endif
    end

    assign free_words = CW'(DEPTH) - count;
    assign accept     = in_avail && (set_len != '0) && (state == ST_IDLE) && (free_words >= set_len);
    assign drop       = in_avail && (set_len != '0) && !accept;
    assign busy       = (state != ST_IDLE);

    // Lowest still-pending channel is the one being emitted
    always_comb begin
        cur_i   = '0;
        cur_q   = '0;
        cur_bit = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (remain[k]) begin
                cur_i   = hold_i[k*W +: W];
                cur_q   = hold_q[k*W +: W];
                cur_bit = NCH'(1) << k;
            end
        end
    end

    assign last_word = (word_idx == wpc_of(mode_h) - 2'd1);
    assign last_chan = ((remain & ~cur_bit) == '0);

    // FSM state register
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef RX_WB_PACK_HDR_EN
                    next_state = ST_HDR;
`else
                    next_state = ST_EMIT;
`endif
                end
            end
            ST_HDR:  next_state = (remain != '0) ? ST_EMIT : ST_IDLE;
            ST_EMIT: begin
                if (last_word && last_chan) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: one FIFO write per HDR/EMIT cycle
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (state)
            ST_HDR: begin
`ifdef RX_WB_PACK_HDR_EN
                wr_en   = 1'b1;
                wr_data = {HDR_TAG, seq};
`endif
            end
            ST_EMIT: begin
                wr_en   = 1'b1;
                wr_data = fmt_word(mode_h, word_idx, cur_i, cur_q);
            end
            default: ;
        endcase
    end

    // Holding registers and channel/word walk through the captured set
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            hold_i   <= '0;
            hold_q   <= '0;
            mode_h   <= MODE_MSB16;
            remain   <= '0;
            word_idx <= '0;
        end else if (accept) begin
            hold_i   <= in_i;
            hold_q   <= in_q;
            mode_h   <= mode;
            remain   <= ch_en;
            word_idx <= '0;
        end else if (state == ST_EMIT) begin
            if (last_word) begin
                word_idx <= '0;
                remain   <= remain & ~cur_bit;
            end else begin
                word_idx <= word_idx + 2'd1;
            end
        end
    end

`ifdef RX_WB_PACK_HDR_EN
    // Sequence number advances once per accepted set, after its header is written
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            seq <= '0;
        end else if (state == ST_HDR) begin
            seq <= seq + 12'd1;
        end
    end
`endif

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    rx_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (adc_clk),
        .rst      (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count)
    );

endmodule

// File: doc/rx_wb_pack.md
# rx_wb_pack

Parametrised, multi-channel successor to the single-channel wideband RX output path. Accepts NCH channels of decimated I/Q samples, which share one `in_avail` strobe. It packs each sample set into 16-bit words in one of three selectable formats and buffers them in a FIFO for the readout engine. It sits between the per-channel CIC outputs and the host-facing sample readout, all in the `adc_clk` domain.

## Interface
- `NCH`, 4: number of channels, 1..8
- `IN_WIDTH`, 18: sample width per I or Q, 17..24
- `DEPTH`, 64: FIFO depth in 16-bit words, a power of 2, at least 32
- `adc_clk`  in  1  sole clock
- `reset`  in  1  reset; asynchronous and active-high
- `in_avail`  in  1  one-cycle strobe: a new sample set is present on `in_i`/`in_q`
- `in_i`  in  NCH*IN_WIDTH  signed I samples; channel k is at bits [k*IN_WIDTH +: IN_WIDTH]
- `in_q`  in  NCH*IN_WIDTH  signed Q samples, same layout as `in_i`
- `ch_en`  in  NCH  per-channel enable
- `mode`  in  2  packing format: 0 = MSB16, 1 = FULL, 2 = PACK8, 3 = treated as 0
- `rd_en`  in  1  pop one word
- `rd_data`  out  16  registered read data; reset value 0
- `rd_valid`  out  1  `rd_data` is valid this cycle; reset value 0
- `count`  out  clog2(DEPTH)+1  FIFO word occupancy; reset value 0
- `busy`  out  1  a sample set is being emitted; reset value 0
- `ovf`  out  1  sticky: a set was dropped; reset value 0
- `ovf_clr`  in  1  clears `ovf`

## Operation
- Capture: on `in_avail` with the FSM in IDLE, latch all of `in_i`, `in_q`, `ch_en` and `mode` into holding registers.
- Words per enabled channel (wpc): 2 in MSB16, 3 in FULL, 1 in PACK8.
- Set length L = popcount(`ch_en`) × wpc, plus 1 when the header is configured in.
- Atomic admission: a set is accepted only if DEPTH − `count` ≥ L at the capture cycle. Otherwise the whole set is dropped and `ovf` is set.
- Overrun: `in_avail` while `busy` drops that set and sets `ovf`. The set in progress completes untouched.
- L = 0 (no channels enabled and no header): the set is ignored and `ovf` is not affected.
- Word formats per channel, emitted in ascending channel order with disabled channels skipped:
  - MSB16: I[IN_WIDTH-1 -: 16], then Q[IN_WIDTH-1 -: 16]
  - FULL: I[15:0], then Q[15:0], then {sext8(I[IN_WIDTH-1:16]), sext8(Q[IN_WIDTH-1:16])}
  - PACK8: {I[IN_WIDTH-1 -: 8], Q[IN_WIDTH-1 -: 8]}
- FSM states:
  - IDLE: go to HDR (macro on) or EMIT (macro off) on an accepted capture.
  - HDR: write one header word, then go to EMIT.
  - EMIT: write one word per cycle through channel index and word index; after the last word of the last enabled channel, return to IDLE.
- FIFO: circular buffer with wrap-around read and write pointers.
  - Read on empty is ignored: `rd_valid` stays 0 and no state changes.
  - Simultaneous read and write leave `count` unchanged.
  - Writes never hit a full FIFO, because admission reserves the space.
- `ovf_clr` and a new overflow event in the same cycle: `ovf` ends at 1 (set wins).
- `reset` mid-set: the FSM returns to IDLE, the FIFO is emptied, and all outputs return to their reset values.

## Timing
- `in_avail` at cycle T: capture at T.
  - First word is written at T+1.
  - `count` reflects it at T+2.
  - The last word is written at T+L.
  - `busy` is high from T+1 to T+L.
- The next set is accepted only from cycle T+L+1. The maximum sustained set rate is one per L+1 cycles.
- `rd_en` at cycle R with `count` > 0: `rd_data` and `rd_valid` are valid at R+1, and `count` decrements at R+1.
- Back-to-back `rd_en` gives one word per cycle.

## Configuration
- `RX_WB_PACK_HDR_EN` defined:
  - Each accepted set is prefixed by the header {4'hA, seq[11:0]}.
  - `seq` starts at 0 after reset and increments by 1 for each accepted set, wrapping at 4095.
  - Dropped sets do not increment `seq`, so gaps are visible to the host only through `ovf`.
- `RX_WB_PACK_HDR_EN` undefined: the HDR state, `seq` and the +1 term in L are absent.

## Structure
- Shared package holds:
  - mode encodings (`MODE_MSB16`, `MODE_FULL`, `MODE_PACK8`)
  - FSM state encodings
  - `HDR_TAG` = 4'hA
  - the wpc-per-mode function
- Sub-module `rx_wb_fifo`: single-clock circular buffer with `count`, registered read and async reset.
- Capture, FSM and word formatting live in `rx_wb_pack`.

## Test plan
- MSB16 test:
  - Stimulus: NCH=4, `ch_en`=4'b0101, `mode`=0, ch0 I=18'h1ABCD, Q=18'h2_0001, header off.
  - Response: exactly 4 words; the first two are 16'h6AF3 and 16'h8000; `count`=4 at T+5.
- FULL test:
  - Stimulus: `mode`=1, ch0 only, I=18'h3FFFF, Q=18'h10000.
  - Response: words 16'hFFFF, 16'h0000, 16'hFF01.
- PACK8 test:
  - Stimulus: `mode`=2, all 4 channels enabled, I=18'h20000, Q=18'h1FFFF on every channel.
  - Response: 4 words, each 16'h807F.
- Admission test:
  - Stimulus: DEPTH=64, fill to `count`=60, then send a FULL set with 2 channels (L=6).
  - Response: set dropped, `ovf`=1, `count` stays 60. After `ovf_clr` and 2 reads, the same set is accepted.
- Overrun test:
  - Stimulus: `in_avail` at T and again at T+3 with L=8.
  - Response: the second set is dropped, `ovf`=1, and exactly 8 words are written.
- Header and reset test:
  - Stimulus: `RX_WB_PACK_HDR_EN` defined, accept 3 sets, assert `reset` during the 3rd set's EMIT.
  - Response: headers 16'hA000 and 16'hA001 are seen first; after reset, `count`=0, `busy`=0, and the next header is 16'hA000.
